// File: rtl/counter_checker_if.sv
// Sample stream seen by counter_checker: the observed counter value, a
// qualifier saying the value is a real sample, and a flag telling the
// checker that the observed counter was held in reset for that sample.
interface counter_checker_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] value_in;
  logic             valid_in;
  logic             dut_rst_in;

  // The bench or the counter wrapper drives the stream
  modport master (output value_in, valid_in, dut_rst_in);

  // The checker only ever observes it
  modport slave (input value_in, valid_in, dut_rst_in);
endinterface

// File: rtl/counter_checker.sv
// counter_checker: watches the sampled output of an up-counter and checks
// that every sample is the previous one plus one (modulo 2^WIDTH).
// The first sample after reset only provides the reference value. A
// mismatch resynchronises the reference to the observed value, so a single
// skipped count costs exactly one error. MAX_MISS mismatches in a row park
// the checker in a sticky FAULT state that only reset can clear.
// All outputs come straight from flops.
module counter_checker #(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 16,
  parameter int MAX_MISS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  counter_checker_if.slave      smp,
  output logic                  locked,
  output logic                  err_pulse,
  output logic                  fault,
  output logic [CNT_W-1:0]      err_count,
  output logic [CNT_W-1:0]      sample_count,
  output logic [WIDTH-1:0]      bad_value,
  output logic [WIDTH-1:0]      exp_value
);

  // The miss-run counter never has to go past MAX_MISS (at most 255)
  localparam logic [7:0] MaxMiss = 8'(MAX_MISS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t           state_q;
  logic             locked_q;
  logic             errPulse_q;
  logic             fault_q;
  logic [CNT_W-1:0] errCount_q;
  logic [CNT_W-1:0] sampleCount_q;
  logic [WIDTH-1:0] badValue_q;
  logic [WIDTH-1:0] expValue_q;
  logic [7:0]       missRun_q;

  logic [CNT_W-1:0] errCount_d;
  logic [CNT_W-1:0] sampleCount_d;
  logic [7:0]       missRun_d;
  logic [WIDTH-1:0] valuePlusOne;
  logic             isMatch;

  // Saturating counter increments, the wrapped successor of the observed
  // value and the compare result, shared by every branch of the FSM
  always_comb begin
    errCount_d    = (&errCount_q)    ? errCount_q    : errCount_q + CNT_W'(1);
    sampleCount_d = (&sampleCount_q) ? sampleCount_q : sampleCount_q + CNT_W'(1);
    missRun_d     = missRun_q + 8'd1;
    valuePlusOne  = smp.value_in + WIDTH'(1);
    isMatch       = (smp.value_in == expValue_q);
  end

  // Checker FSM together with every output register; reset wins over any
  // sample presented on the same edge, and the error pulse self-clears
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      locked_q      <= 1'b0;
      errPulse_q    <= 1'b0;
      fault_q       <= 1'b0;
      errCount_q    <= '0;
      sampleCount_q <= '0;
      badValue_q    <= '0;
      expValue_q    <= '0;
      missRun_q     <= '0;
    end else begin
      errPulse_q <= 1'b0;
      if (smp.valid_in) begin
        case (state_q)
          IDLE: begin
            expValue_q <= smp.dut_rst_in ? '0 : valuePlusOne;
            locked_q   <= 1'b1;
            state_q    <= TRACK;
          end
          TRACK: begin
            if (smp.dut_rst_in) begin
              expValue_q <= '0;
              missRun_q  <= '0;
            end else begin
              sampleCount_q <= sampleCount_d;
              expValue_q    <= valuePlusOne;
              if (isMatch) begin
                missRun_q <= '0;
              end else begin
                errPulse_q <= 1'b1;
                errCount_q <= errCount_d;
                badValue_q <= smp.value_in;
                missRun_q  <= missRun_d;
                if (missRun_d == MaxMiss) begin
                  state_q  <= FAULT;
                  fault_q  <= 1'b1;
                  locked_q <= 1'b0;
                end
              end
            end
          end
          FAULT: begin
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign locked       = locked_q;
  assign err_pulse    = errPulse_q;
  assign fault        = fault_q;
  assign err_count    = errCount_q;
  assign sample_count = sampleCount_q;
  assign bad_value    = badValue_q;
  assign exp_value    = expValue_q;

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker. Each directed step drives one cycle of
// stimulus, advances a behavioural model of the checker and queues the
// outputs the model predicts; right after the edge the queued prediction is
// popped and compared with what the checker shows. Scenario checks with
// hand-derived constants sit on top of the scoreboard. A second instance
// with narrow counters and a large miss limit shares the stimulus and is
// only examined in the saturation scenario.
module tb_counter_checker;

  localparam int WIDTH    = 8;
  localparam int CNT_W    = 16;
  localparam int MAX_MISS = 4;

  typedef struct packed {
    logic             locked;
    logic             errPulse;
    logic             fault;
    logic [CNT_W-1:0] errCount;
    logic [CNT_W-1:0] sampleCount;
    logic [WIDTH-1:0] badValue;
    logic [WIDTH-1:0] expValue;
  } outT;

  typedef enum { M_IDLE, M_TRACK, M_FAULT } mState_t;

  logic clk = 1'b0;
  logic reset;

  logic             locked, errPulse, fault;
  logic [CNT_W-1:0] errCount, sampleCount;
  logic [WIDTH-1:0] badValue, expValue;

  logic             satLocked, satErrPulse, satFault;
  logic [3:0]       satErrCount, satSampleCount;
  logic [WIDTH-1:0] satBadValue, satExpValue;

  int      checks = 0;
  int      errors = 0;
  string   curTag = "init";
  outT     expQ[$];
  outT     model;
  mState_t mState;
  int      mMiss;

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  counter_checker_if #(.WIDTH(WIDTH)) smpIf ();

  counter_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W), .MAX_MISS(MAX_MISS)) dut (
    .clk(clk), .reset(reset), .smp(smpIf.slave),
    .locked(locked), .err_pulse(errPulse), .fault(fault),
    .err_count(errCount), .sample_count(sampleCount),
    .bad_value(badValue), .exp_value(expValue)
  );

  counter_checker #(.WIDTH(WIDTH), .CNT_W(4), .MAX_MISS(255)) satDut (
    .clk(clk), .reset(reset), .smp(smpIf.slave),
    .locked(satLocked), .err_pulse(satErrPulse), .fault(satFault),
    .err_count(satErrCount), .sample_count(satSampleCount),
    .bad_value(satBadValue), .exp_value(satExpValue)
  );

  // Behavioural model of one clock edge for the default-parameter checker
  task automatic modelStep(input logic rst, input logic v, input logic drst,
                           input logic [WIDTH-1:0] val);
    if (rst) begin
      model  = '0;
      mState = M_IDLE;
      mMiss  = 0;
    end else begin
      model.errPulse = 1'b0;
      if (v) begin
        if (mState == M_IDLE) begin
          model.expValue = drst ? 8'd0 : val + 8'd1;
          model.locked   = 1'b1;
          mState         = M_TRACK;
        end else if (mState == M_TRACK) begin
          if (drst) begin
            model.expValue = 8'd0;
            mMiss          = 0;
          end else begin
            if (model.sampleCount != 16'hFFFF) model.sampleCount++;
            if (val == model.expValue) begin
              mMiss = 0;
            end else begin
              model.errPulse = 1'b1;
              if (model.errCount != 16'hFFFF) model.errCount++;
              model.badValue = val;
              mMiss++;
              if (mMiss == MAX_MISS) begin
                mState       = M_FAULT;
                model.fault  = 1'b1;
                model.locked = 1'b0;
              end
            end
            model.expValue = val + 8'd1;
          end
        end
      end
    end
  endtask

  // Pop the prediction for this edge and compare it with the checker outputs
  task automatic checkOutput();
    outT obs;
    outT expv;
    obs.locked      = locked;
    obs.errPulse    = errPulse;
    obs.fault       = fault;
    obs.errCount    = errCount;
    obs.sampleCount = sampleCount;
    obs.badValue    = badValue;
    obs.expValue    = expValue;
    checks++;
    if (expQ.size() == 0) begin
      errors++;
      $error("[TB] FAIL %s scoreboard: got 0 queued predictions, expected 1", curTag);
    end else begin
      expv = expQ.pop_front();
      assert (obs === expv) else begin
        errors++;
        $error("[TB] FAIL %s: got %h expected %h", curTag, obs, expv);
      end
    end
  endtask

  // Directed check of a single value against a hand-derived constant
  task automatic checkValue(input string tag, input logic [31:0] obs,
                            input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Drive one cycle, queue the prediction, then check just after the edge
  task automatic applyStimulus(input logic rst, input logic v, input logic drst,
                               input logic [WIDTH-1:0] val);
    reset            = rst;
    smpIf.valid_in   = v;
    smpIf.dut_rst_in = drst;
    smpIf.value_in   = val;
    modelStep(rst, v, drst, val);
    expQ.push_back(model);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic sample(input logic [WIDTH-1:0] val);
    applyStimulus(1'b0, 1'b1, 1'b0, val);
  endtask

  // Directed scenarios, one after another
  initial begin
    model  = '0;
    mState = M_IDLE;
    mMiss  = 0;

    curTag = "reset";
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    checkValue("reset_locked", 32'(locked), 0);
    checkValue("reset_err_count", 32'(errCount), 0);
    checkValue("reset_exp_value", 32'(expValue), 0);

    curTag = "lock_wrap";
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    sample(8'd0);
    checkValue("wrap_locked_first", 32'(locked), 1);
    checkValue("wrap_no_count_on_lock", 32'(sampleCount), 0);
    for (int i = 1; i < 258; i++) sample(8'(i));
    checkValue("wrap_err_count", 32'(errCount), 0);
    checkValue("wrap_sample_count", 32'(sampleCount), 257);
    checkValue("wrap_exp_value", 32'(expValue), 2);

    curTag = "single_skip";
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    sample(8'd10);
    sample(8'd11);
    checkValue("skip_no_pulse_yet", 32'(errPulse), 0);
    sample(8'd13);
    checkValue("skip_pulse", 32'(errPulse), 1);
    checkValue("skip_bad_value", 32'(badValue), 13);
    sample(8'd14);
    checkValue("skip_pulse_cleared", 32'(errPulse), 0);
    checkValue("skip_err_count", 32'(errCount), 1);
    checkValue("skip_fault", 32'(fault), 0);

    curTag = "counter_reset";
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    sample(8'd40);
    sample(8'd41);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd0);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'd0);
    sample(8'd0);
    sample(8'd1);
    sample(8'd2);
    checkValue("crst_err_count", 32'(errCount), 0);
    checkValue("crst_exp_value", 32'(expValue), 3);
    checkValue("crst_sample_count", 32'(sampleCount), 4);

    curTag = "fault";
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    sample(8'd5);
    sample(8'd9);
    sample(8'd20);
    sample(8'd7);
    checkValue("fault_not_yet", 32'(fault), 0);
    sample(8'd30);
    checkValue("fault_set", 32'(fault), 1);
    checkValue("fault_unlocked", 32'(locked), 0);
    checkValue("fault_err_count", 32'(errCount), 4);
    sample(8'd31);
    sample(8'd99);
    checkValue("fault_frozen_err", 32'(errCount), 4);
    checkValue("fault_frozen_samples", 32'(sampleCount), 4);
    checkValue("fault_frozen_exp", 32'(expValue), 31);
    checkValue("fault_sticky", 32'(fault), 1);

    curTag = "valid_gaps";
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      sample(8'(i));
      if (i < 5) applyStimulus(1'b0, 1'b0, 1'b0, 8'(i));
    end
    checkValue("gaps_err_count", 32'(errCount), 0);
    checkValue("gaps_sample_count", 32'(sampleCount), 5);

    curTag = "saturation";
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    sample(8'd0);
    for (int i = 0; i < 15; i++) sample(8'd100);
    checkValue("sat_err_at_15", 32'(satErrCount), 15);
    for (int i = 0; i < 5; i++) sample(8'd100);
    checkValue("sat_err_held", 32'(satErrCount), 15);
    checkValue("sat_samples_held", 32'(satSampleCount), 15);
    checkValue("sat_no_fault", 32'(satFault), 0);
    checkValue("sat_locked", 32'(satLocked), 1);

    curTag = "reset_priority";
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0);
    sample(8'd50);
    sample(8'd51);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd99);
    checkValue("rprio_pulse", 32'(errPulse), 0);
    checkValue("rprio_locked", 32'(locked), 0);
    checkValue("rprio_err_count", 32'(errCount), 0);
    checkValue("rprio_exp_value", 32'(expValue), 0);
    sample(8'd7);
    checkValue("rprio_relock", 32'(locked), 1);
    checkValue("rprio_relock_exp", 32'(expValue), 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
